// File: rtl/avalon_gpio_ctrl.sv
// ============================================================================
// avalon_gpio_ctrl
// ----------------------------------------------------------------------------
// Parametrised Avalon-MM GPIO slave with zero wait states.
//  - An output register of DATA_W bits drives out_port.
//  - in_port passes through a 2-flop synchroniser. A third flop keeps the
//    previous sample, and edges are captured per bit in a sticky register.
//  - A level interrupt (irq) is raised when any captured edge is unmasked.
//
// Optional feature (macro AVALON_GPIO_BITSET_EN):
//  - defined   : address 4 sets out_reg bits, address 5 clears out_reg bits,
//                and both addresses read back out_reg.
//  - undefined : addresses 4 and 5 read 0 and ignore writes.
//
// Parameters:
//  DATA_W      width of in_port/out_port, 1..32
//  RESET_VALUE out_reg value at reset (low DATA_W bits used)
//  EDGE_TYPE   0 rising, 1 falling, 2 any edge
//
// Ports:
//  clk         system clock (single domain)
//  reset_n     asynchronous active-low reset
//  address     word address [2:0]
//  chipselect  slave select
//  write_n     active-low write strobe
//  writedata   32-bit write data, bits [DATA_W-1:0] used
//  readdata    32-bit combinational read data, upper bits 0
//  in_port     asynchronous external inputs
//  out_port    output register contents
//  irq         registered interrupt, active high
//
// Register map (word address):
//  0 DATA (rd in_sync / wr out_reg), 1 OUTRB (rd/wr out_reg),
//  2 IRQMASK, 3 EDGECAP (write-1-to-clear), 4 OUTSET, 5 OUTCLR, 6..7 reserved
// ============================================================================
module avalon_gpio_ctrl #(
    parameter int          DATA_W      = 4,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          EDGE_TYPE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic              irq
);

    localparam logic [DATA_W-1:0] RST_OUT = RESET_VALUE[DATA_W-1:0];

    logic [DATA_W-1:0] out_reg_q,  out_reg_d;
    logic [DATA_W-1:0] irq_mask_q, irq_mask_d;
    logic [DATA_W-1:0] edge_cap_q, edge_cap_d;
    logic [DATA_W-1:0] s1_q,       s1_d;
    logic [DATA_W-1:0] in_sync_q,  in_sync_d;
    logic [DATA_W-1:0] in_prev_q,  in_prev_d;
    logic              irq_q,      irq_d;

    logic              wr_s;
    logic [DATA_W-1:0] wd_s;
    logic [DATA_W-1:0] clr_s;
    logic [DATA_W-1:0] rise_s;
    logic [DATA_W-1:0] fall_s;
    logic [DATA_W-1:0] edge_s;
    logic [DATA_W-1:0] rd_s;

    // Only the low DATA_W bits of writedata carry register content.
    wire unused_wd_s = ^{1'b0, writedata};

    assign wr_s = chipselect & ~write_n;
    assign wd_s = writedata[DATA_W-1:0];

    // Edge detection between the synchronised sample and the one before it.
    always_comb begin
        rise_s = in_sync_q & ~in_prev_q;
        fall_s = ~in_sync_q & in_prev_q;
        case (EDGE_TYPE)
            0:       edge_s = rise_s;
            1:       edge_s = fall_s;
            2:       edge_s = rise_s | fall_s;
            default: edge_s = rise_s;
        endcase
    end

    // Register write decode; reserved addresses fall through to a no-op.
    always_comb begin
        out_reg_d  = out_reg_q;
        irq_mask_d = irq_mask_q;
        clr_s      = '0;
        if (wr_s) begin
            case (address)
                3'd0, 3'd1: out_reg_d  = wd_s;
                3'd2:       irq_mask_d = wd_s;
                3'd3:       clr_s      = wd_s;
`ifdef AVALON_GPIO_BITSET_EN
                3'd4:       out_reg_d  = out_reg_q | wd_s;
                3'd5:       out_reg_d  = out_reg_q & ~wd_s;
`endif
                default: begin
                    out_reg_d  = out_reg_q;
                    irq_mask_d = irq_mask_q;
                end
            endcase
        end else begin
            clr_s = '0;
        end
    end

    // Input pipeline, sticky edge capture and interrupt.
    // A new edge overrides a simultaneous write-1-clear of the same bit.
    always_comb begin
        s1_d       = in_port;
        in_sync_d  = s1_q;
        in_prev_d  = in_sync_q;
        edge_cap_d = edge_s | (edge_cap_q & ~clr_s);
        irq_d      = |(edge_cap_q & irq_mask_q);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg_q  <= RST_OUT;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            s1_q       <= '0;
            in_sync_q  <= '0;
            in_prev_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            out_reg_q  <= out_reg_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            s1_q       <= s1_d;
            in_sync_q  <= in_sync_d;
            in_prev_q  <= in_prev_d;
            irq_q      <= irq_d;
        end
    end

    // Read mux: purely combinational from address, independent of chipselect.
    always_comb begin
        rd_s = '0;
        case (address)
            3'd0:    rd_s = in_sync_q;
            3'd1:    rd_s = out_reg_q;
            3'd2:    rd_s = irq_mask_q;
            3'd3:    rd_s = edge_cap_q;
`ifdef AVALON_GPIO_BITSET_EN
            3'd4:    rd_s = out_reg_q;
            3'd5:    rd_s = out_reg_q;
`endif
            default: rd_s = '0;
        endcase
        readdata               = 32'd0;
        readdata[DATA_W-1:0]   = rd_s;
    end

    assign out_port = out_reg_q;
    assign irq      = irq_q;

endmodule
